// File: rtl/red_tx_pkg.sv
// Shared types and constants for the RED filtered-sample UART transmitter.
// Build option: define RED_TX_PARITY_EN to add an even-parity bit to every byte.
package red_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef RED_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } tx_state_e;

  localparam logic [3:0] HDR_NIBBLE      = 4'hA;
  localparam int         BYTES_PER_FRAME = 3;
  localparam int         DATA_BITS       = 8;

`ifdef RED_TX_PARITY_EN
  localparam bit PARITY_EN     = 1'b1;
  localparam int BITS_PER_BYTE = 11;
`else
  localparam bit PARITY_EN     = 1'b0;
  localparam int BITS_PER_BYTE = 10;
`endif

  // Byte idx of the frame for sample s: header nibble + MSBs, then middle, then LSBs.
  function automatic logic [7:0] frame_byte(input logic [19:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {HDR_NIBBLE, s[19:16]};
      2'd1:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/red_uart_byte_tx.sv
// One-byte UART serializer: start, 8 data bits LSB first, optional even parity, stop.
// Build option: RED_TX_PARITY_EN enables the parity state.
module red_uart_byte_tx
  import red_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK_Filter,
  input  logic       rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       busy,
  output logic       tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef RED_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  // byte_done is asserted during the final stop-bit cycle so a chained start lands with no gap.
  assign byte_done = (r_state == ST_STOP) && w_bit_end;
  assign busy      = (r_state != ST_IDLE);
  assign tx        = r_tx;

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef RED_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE || w_bit_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (byte_start) begin
            r_state  <= ST_START;
            r_shift  <= byte_data;
            r_tx     <= 1'b0;
`ifdef RED_TX_PARITY_EN
            r_parity <= ^byte_data;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit == BIT_LAST) begin
`ifdef RED_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end
        end
`ifdef RED_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (byte_start) begin
              r_state  <= ST_START;
              r_shift  <= byte_data;
              r_tx     <= 1'b0;
`ifdef RED_TX_PARITY_EN
              r_parity <= ^byte_data;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/red_filt_uart_tx.sv
// Decimates the RED FIR output and ships each kept sample as a 3-byte UART frame.
// Build option: RED_TX_PARITY_EN adds even parity per byte (see red_uart_byte_tx).
module red_filt_uart_tx
  import red_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DECIM        = 4
) (
  input  logic        CLK_Filter,
  input  logic        rst_n,
  input  logic [19:0] Out_RED_Filtered,
  input  logic        sample_valid,
  input  logic        ovr_clr,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam int                DCNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [1:0]        IDX_LAST  = 2'(BYTES_PER_FRAME - 1);

  logic [DCNT_W-1:0] r_dcnt;
  logic [19:0]       r_shadow;
  logic [1:0]        r_byte_idx;
  logic              r_overrun;

  logic       w_hit;
  logic       w_busy;
  logic       w_byte_done;
  logic       w_capture;
  logic       w_next_byte;
  logic       w_byte_start;
  logic [7:0] w_byte_data;

  assign w_hit        = sample_valid && (r_dcnt == DCNT_LAST);
  assign w_capture    = w_hit && !w_busy;
  assign w_next_byte  = w_byte_done && (r_byte_idx < IDX_LAST);
  assign w_byte_start = w_capture || w_next_byte;
  // On capture the shadow is not loaded yet, so byte0 comes straight from the input.
  assign w_byte_data  = w_capture ? frame_byte(Out_RED_Filtered, 2'd0)
                                  : frame_byte(r_shadow, 2'(r_byte_idx + 2'd1));

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt     <= '0;
      r_shadow   <= '0;
      r_byte_idx <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + 1'b1;
      end
      if (w_capture) begin
        r_shadow   <= Out_RED_Filtered;
        r_byte_idx <= '0;
      end else if (w_next_byte) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_hit && w_busy) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  red_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .CLK_Filter(CLK_Filter),
    .rst_n     (rst_n),
    .byte_start(w_byte_start),
    .byte_data (w_byte_data),
    .byte_done (w_byte_done),
    .busy      (w_busy),
    .tx        (tx)
  );

  assign busy    = w_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_red_filt_uart_tx.sv
// Self-checking bench for red_filt_uart_tx: directed cases plus random stimulus
// against a cycle-level waveform model derived from the frame format.
module tb_red_filt_uart_tx;

  localparam int CPB = 4;
  localparam int DEC = 3;
`ifdef RED_TX_PARITY_EN
  localparam int B = 11;
`else
  localparam int B = 10;
`endif
  localparam int FRAME = 3 * B * CPB;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] din   = '0;
  logic        vld   = 1'b0;
  logic        clr   = 1'b0;
  logic        tx;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  red_filt_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DECIM       (DEC)
  ) dut (
    .CLK_Filter      (clk),
    .rst_n           (rst_n),
    .Out_RED_Filtered(din),
    .sample_valid    (vld),
    .ovr_clr         (clr),
    .tx              (tx),
    .busy            (busy),
    .overrun         (overrun)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  // Reference model: valid count, capture edge of the current frame, its sample, overrun.
  int          m_vcnt    = 0;
  bit          m_started = 1'b0;
  int          m_edge    = 0;
  logic [19:0] m_sample  = '0;
  logic        m_ovr     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line level t cycles after the capture edge.
  function automatic logic exp_tx(input int t, input logic [19:0] s);
    int         bi;
    int         by;
    int         pos;
    logic [7:0] d;
    bi  = t / CPB;
    by  = bi / B;
    pos = bi % B;
    if (by == 0)      d = {4'hA, s[19:16]};
    else if (by == 1) d = s[15:8];
    else              d = s[7:0];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (B == 11 && pos == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic tick();
    bit hit;
    bit was_busy;
    int t;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_vcnt    = 0;
      m_started = 1'b0;
      m_ovr     = 1'b0;
    end else begin
      hit = vld && ((m_vcnt % DEC) == DEC - 1);
      if (vld) m_vcnt++;
      was_busy = m_started && (cyc - m_edge >= 1) && (cyc - m_edge <= FRAME);
      if (hit && was_busy) begin
        m_ovr = 1'b1;
      end else begin
        if (clr) m_ovr = 1'b0;
        if (hit) begin
          m_started = 1'b1;
          m_edge    = cyc;
          m_sample  = din;
        end
      end
    end
    @(negedge clk);
    t = cyc - m_edge;
    if (m_started && t < FRAME) begin
      chk("busy", busy, 1);
      chk("tx", tx, exp_tx(t, m_sample));
    end else begin
      chk("busy", busy, 0);
      chk("tx", tx, 1);
    end
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [19:0] s);
    din = s;
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  // Pads the decimation phase, then lands the decimated valid on edge edge_no (or asap).
  task automatic hit_at(input int edge_no, input logic [19:0] s, input bit with_clr);
    int pad;
    pad = (DEC - 1) - (m_vcnt % DEC);
    for (int i = 0; i < pad; i++) send(20'($urandom));
    while (cyc < edge_no - 1) tick();
    clr = with_clr;
    send(s);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int eb;
    int ec;
    int er;

    rst_n = 1'b0;
    idle(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(2);

    // Single frame and its exact busy length
    hit_at(cyc + 1, 20'hABCDE, 1'b0);
    chk("a_start_tx", tx, 0);
    chk("a_start_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < FRAME + 8) begin
      tick();
      n++;
    end
    chk("a_busy_len", n, FRAME);

    // Hit in the first idle cycle after a frame is accepted with no gap
    hit_at(cyc + 1, 20'h5A7F0, 1'b0);
    eb = cyc;
    hit_at(eb + FRAME + 1, 20'h13579, 1'b0);
    ec = cyc;
    chk("b2b_tx", tx, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_ovr", overrun, 0);

    // Hit during the last stop-bit cycle is dropped
    hit_at(ec + FRAME, 20'hFFFFF, 1'b0);
    chk("drop_ovr", overrun, 1);
    chk("drop_idle", busy, 0);
    idle(3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovr", overrun, 0);

    // A drop coincident with ovr_clr keeps overrun set
    hit_at(cyc + 1, 20'h0F0F0, 1'b0);
    hit_at(cyc + 10, 20'h11111, 1'b1);
    chk("clr_vs_drop", overrun, 1);
    idle(FRAME);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_after", overrun, 0);

    // Asynchronous reset during byte1 data bit 3 (byte1 = 0xA7, d3 = 0)
    hit_at(cyc + 1, 20'h5A7F0, 1'b0);
    er = cyc;
    while (cyc - er < (B + 4) * CPB + 1) tick();
    chk("pre_rst_tx", tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Decimation: samples 1..8 spaced 200 cycles, only every DEC-th goes out
    for (int v = 1; v <= 8; v++) begin
      send(20'(v));
      if (v % DEC == 0) chk("dec_tx_start", tx, 0);
      else chk("dec_skip_busy", busy, 0);
      idle(199);
    end
    chk("dec_ovr", overrun, 0);
    hit_at(cyc + 1, 20'h12345, 1'b0);
    chk("post_rst_tx", tx, 0);
    idle(FRAME + 2);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      vld = ($urandom_range(0, 11) == 0);
      din = 20'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    vld = 1'b0;
    clr = 1'b0;
    idle(FRAME + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/red_filt_uart_tx.md
# red_filt_uart_tx

Serial transmitter for the RED filtered-sample stream. It sits downstream of the RED FIR filter. It decimates the 20-bit filtered output and captures one sample per decimation period. Each captured sample goes out as a 3-byte UART frame (8N1, optional parity) to the off-chip host, with a sticky overrun flag for samples dropped while a frame is in flight.

## Interface
- CLKS_PER_BIT, 16, clock cycles per UART bit (≥2)
- DECIM, 4, transmit one of every DECIM valid samples (≥1)
- CLK_Filter  in  1  filter clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Out_RED_Filtered  in  20  filtered sample from FIR
- sample_valid  in  1  one-cycle strobe: Out_RED_Filtered holds a new sample
- ovr_clr  in  1  clears overrun
- tx  out  1  UART line, idle high
- busy  out  1  frame in progress
- overrun  out  1  sticky: a decimated sample was dropped

## Operation
- Decimation counter dcnt, 0..DECIM-1, advances on every sample_valid whether or not the block is busy; wraps to 0 after DECIM-1.
- Hit = sample_valid && dcnt==DECIM-1.
- Hit while state IDLE: latch sample into shadow register; start frame.
- Hit while not IDLE: sample dropped, overrun←1, the frame in flight is unaffected.
- Frame is 3 bytes, in order: byte0={4'hA, s[19:16]}, byte1=s[15:8], byte2=s[7:0].
- Byte format: start(0), d[0]..d[7] LSB first, [parity], stop(1).
- FSM: IDLE → START → DATA (8 bits) → [PARITY] → STOP.
  - From STOP: go to START of the next byte if byte index <2, else IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1; every bit is held exactly CLKS_PER_BIT cycles. No idle gap between bytes.
- overrun: set wins over ovr_clr in the same cycle; otherwise ovr_clr clears it.
- Reset values: tx=1, busy=0, overrun=0, dcnt=0, state IDLE, shadow=0.
- Reset mid-frame: frame is abandoned; tx=1 and busy=0 immediately (asynchronous). No partial byte resumes after release.

## Timing
- Capture at edge E (hit in IDLE): tx=0 and busy=1 from E+1.
- Bits per byte B = 10, or 11 with parity. Frame length 3·B·CLKS_PER_BIT cycles; 480 cycles at defaults.
- busy falls on the cycle after the last stop-bit cycle; state is IDLE that same cycle.
- A hit in that first IDLE cycle is accepted. Back-to-back frames have no extra idle bit.
- tx is registered: no glitches, and no combinational path from inputs.

## Configuration
- RED_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between d[7] and stop; B=11.
- RED_TX_PARITY_EN not defined: no parity state; B=10 (8N1).

## Structure
- Package red_tx_pkg holds:
  - FSM state enum
  - HDR_NIBBLE=4'hA
  - BYTES_PER_FRAME=3
  - bit-count constants derived from RED_TX_PARITY_EN
- Sub-module red_uart_byte_tx:
  - byte serializer, containing the baud counter, bit FSM, parity and tx register
  - handshake: byte_start/byte_data in, byte_done out
- Top level holds the decimation counter, the shadow register, byte sequencing and the overrun flag.

## Test plan
- CLKS_PER_BIT=4, DECIM=1, no parity; one valid with 20'hABCDE → tx emits bytes 0xAA, 0xBC, 0xDE, LSB first. tx low from E+1 for 4 cycles. busy high for exactly 120 cycles.
- Same stimulus with RED_TX_PARITY_EN → parity bits 0, 1, 0. busy high for 132 cycles.
- DECIM=4, CLKS_PER_BIT=4; valids every 200 cycles carrying 1..8 → only samples 4 and 8 are transmitted. overrun stays 0.
- DECIM=1; valids 20'h00001 then 20'h00002, 10 cycles apart → only 0x00001 is sent. overrun=1 from the cycle after the second valid. ovr_clr pulse → 0. ovr_clr coincident with a new drop → stays 1.
- rst_n low during byte1 bit 3 → tx=1 and busy=0 immediately. After release, valid 20'h12345 → a complete frame 0xA1, 0x23, 0x45.
- Hit in the first IDLE cycle after a frame → accepted. tx falls on the next edge with no idle bit between frames.
